// File: rtl/fir_sequencer_if.sv
// Handshake bundle between the FIR sequencer and its input FIFO, FIR core and output FIFO.
interface fir_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  enable;
  logic                  in_empty;
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_rd_en;
  logic                  fir_rd_en;
  logic [DATA_WIDTH-1:0] fir_data;
  logic                  fir_valid;
  logic [DATA_WIDTH-1:0] fir_dotprod;
  logic                  fir_done;
  logic                  out_full;
  logic [DATA_WIDTH-1:0] out_din;
  logic                  out_wr_en;

  // Sequencer side
  modport master (
    input  enable, in_empty, in_dout, fir_rd_en, fir_dotprod, fir_done, out_full,
    output in_rd_en, fir_data, fir_valid, out_din, out_wr_en
  );

  // Environment side (FIFOs, FIR core, controller)
  modport slave (
    output enable, in_empty, in_dout, fir_rd_en, fir_dotprod, fir_done, out_full,
    input  in_rd_en, fir_data, fir_valid, out_din, out_wr_en
  );
endinterface

// File: rtl/fir_sequencer.sv
// Moves DECIMATION_FACTOR samples from a FWFT FIFO into a FIR, waits for the
// dot product (with timeout) and pushes it into the output FIFO.
module fir_sequencer #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned DECIMATION_FACTOR = 1,
  parameter int unsigned TIMEOUT_CYCLES    = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  fir_sequencer_if.master       bus,
  output logic                  busy,
  output logic                  error,
  output logic [15:0]           samples_out,
  output logic [15:0]           stall_cycles
);

  localparam int unsigned FEED_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [FEED_W-1:0] FEED_LAST = FEED_W'(DECIMATION_FACTOR - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_WAIT_RESULT,
    S_WRITE_OUT
  } state_t;

  state_t                r_state;
  logic [FEED_W-1:0]     r_feed_cnt;
  logic [CNT_W-1:0]      r_timeout_cnt;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_error;
  logic [CNT_W-1:0]      r_samples;
  logic [CNT_W-1:0]      r_stall;

  state_t                w_state_nxt;
  logic [FEED_W-1:0]     w_feed_cnt_nxt;
  logic [CNT_W-1:0]      w_timeout_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_result_nxt;
  logic                  w_error_nxt;
  logic [CNT_W-1:0]      w_samples_nxt;
  logic [CNT_W-1:0]      w_stall_nxt;
  logic                  w_xfer;
  logic                  w_push;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_feed_cnt    <= '0;
      r_timeout_cnt <= '0;
      r_result      <= '0;
      r_error       <= 1'b0;
      r_samples     <= '0;
      r_stall       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_feed_cnt    <= w_feed_cnt_nxt;
      r_timeout_cnt <= w_timeout_cnt_nxt;
      r_result      <= w_result_nxt;
      r_error       <= w_error_nxt;
      r_samples     <= w_samples_nxt;
      r_stall       <= w_stall_nxt;
    end
  end

  // Next-state, counters and handshake strobes
  always_comb begin
    w_state_nxt       = r_state;
    w_feed_cnt_nxt    = r_feed_cnt;
    w_timeout_cnt_nxt = '0;
    w_result_nxt      = r_result;
    w_error_nxt       = r_error;
    w_samples_nxt     = r_samples;
    w_stall_nxt       = r_stall;
    w_xfer            = 1'b0;
    w_push            = 1'b0;

    // A result strobe while not waiting for one is a protocol violation.
    if (bus.fir_done && (r_state != S_WAIT_RESULT)) begin
      w_error_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          w_state_nxt = S_FEED;
        end
      end
      S_FEED: begin
        w_xfer = !bus.in_empty && bus.fir_rd_en;
        if (w_xfer) begin
          if (r_feed_cnt == FEED_LAST) begin
            w_feed_cnt_nxt = '0;
            w_state_nxt    = S_WAIT_RESULT;
          end else begin
            w_feed_cnt_nxt = r_feed_cnt + FEED_W'(1);
          end
        end
      end
      S_WAIT_RESULT: begin
        if (bus.fir_done) begin
          w_result_nxt = bus.fir_dotprod;
          w_state_nxt  = S_WRITE_OUT;
        end else if (r_timeout_cnt == TO_LAST) begin
          w_error_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_timeout_cnt_nxt = r_timeout_cnt + CNT_W'(1);
        end
      end
      S_WRITE_OUT: begin
        if (!bus.out_full) begin
          w_push = 1'b1;
          if (r_samples != CNT_MAX) begin
            w_samples_nxt = r_samples + CNT_W'(1);
          end
          w_state_nxt = bus.enable ? S_FEED : S_IDLE;
        end else if (r_stall != CNT_MAX) begin
          w_stall_nxt = r_stall + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Zero-latency pop-to-FIR path and registered status
  assign bus.in_rd_en  = w_xfer;
  assign bus.fir_valid = w_xfer;
  assign bus.fir_data  = bus.in_dout;
  assign bus.out_wr_en = w_push;
  assign bus.out_din   = r_result;
  assign busy          = (r_state != S_IDLE);
  assign error         = r_error;
  assign samples_out   = r_samples;
  assign stall_cycles  = r_stall;

endmodule

// File: tb/tb_fir_sequencer.sv
// Randomized scoreboard bench for fir_sequencer (DECIMATION_FACTOR=4, TIMEOUT_CYCLES=8).
module tb_fir_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned DF = 4;
  localparam int unsigned TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        busy;
  logic        error;
  logic [15:0] samples_out;
  logic [15:0] stall_cycles;

  fir_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  fir_sequencer #(
    .DATA_WIDTH(DW),
    .DECIMATION_FACTOR(DF),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .error(error),
    .samples_out(samples_out),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the four operating phases of the protocol
  typedef enum {M_IDLE, M_FEED, M_WAIT, M_WRITE} mphase_t;

  mphase_t     m_phase = M_IDLE;
  int          m_cnt = 0;
  int          m_wait = 0;
  bit          m_err = 1'b0;
  int          m_samples = 0;
  int          m_stall = 0;
  logic [31:0] m_result = '0;
  int          m_groups_fed = 0;

  logic [31:0] in_q[$];
  logic [31:0] dot_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] push_log[$];

  bit run_en = 1'b0;
  int target = 0;
  bit k_starve = 1'b0;
  bit k_rdy_rand = 1'b0;
  bit k_full_rand = 1'b0;
  int k_delay = 3;
  int bp_left = 0;
  int spur_after_pop = 0;
  bit spur_arm = 1'b0;
  bit toggle = 1'b0;
  int cd = 0;
  int dut_pops = 0;

  function automatic void model_reset();
    m_phase  = M_IDLE;
    m_cnt    = 0;
    m_wait   = 0;
    m_err    = 1'b0;
    m_samples = 0;
    m_stall  = 0;
    m_result = '0;
    exp_q.delete();
    cd       = 0;
    spur_arm = 1'b0;
    bp_left  = 0;
  endfunction

  task automatic drive();
    toggle = ~toggle;
    bus.fir_done    = 1'b0;
    bus.fir_dotprod = $urandom;
    if (cd > 0) begin
      cd--;
      if (cd == 0) bus.fir_done = 1'b1;
    end
    if (spur_arm) begin
      bus.fir_done = 1'b1;
      spur_arm = 1'b0;
    end
    if (bus.fir_done && dot_q.size() > 0) bus.fir_dotprod = dot_q.pop_front();
    bus.in_empty  = (in_q.size() == 0) || (k_starve && toggle);
    bus.in_dout   = (in_q.size() > 0) ? in_q[0] : $urandom;
    bus.fir_rd_en = k_rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.out_full  = 1'b0;
    if (m_phase == M_WRITE) begin
      if (bp_left > 0) begin
        bus.out_full = 1'b1;
        bp_left--;
      end else if (k_full_rand) begin
        bus.out_full = ($urandom_range(0, 3) == 0);
      end
    end
    bus.enable = run_en && (m_groups_fed < target);
  endtask

  // One clock cycle: drive, check against the model at negedge, advance model at posedge
  task automatic step();
    bit exp_pop;
    bit exp_wr;
    drive();
    @(negedge clock);
    check("error", 32'(error), 32'(m_err));
    check("samples_out", 32'(samples_out), 32'(m_samples));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    check("busy", 32'(busy), 32'(m_phase != M_IDLE));
    check("out_din", bus.out_din, m_result);
    exp_pop = (m_phase == M_FEED) && !bus.in_empty && bus.fir_rd_en;
    exp_wr  = (m_phase == M_WRITE) && !bus.out_full;
    check("in_rd_en", 32'(bus.in_rd_en), 32'(exp_pop));
    check("fir_valid", 32'(bus.fir_valid), 32'(exp_pop));
    check("out_wr_en", 32'(bus.out_wr_en), 32'(exp_wr));
    if (m_phase == M_FEED) check("fir_data", bus.fir_data, bus.in_dout);
    if (bus.in_rd_en === 1'b1) dut_pops++;
    @(posedge clock);
    if (bus.fir_done && m_phase != M_WAIT) m_err = 1'b1;
    case (m_phase)
      M_IDLE: if (bus.enable) m_phase = M_FEED;
      M_FEED: begin
        if (exp_pop) begin
          void'(in_q.pop_front());
          m_cnt++;
          if (spur_after_pop != 0 && m_cnt == spur_after_pop) begin
            spur_arm = 1'b1;
            spur_after_pop = 0;
          end
          if (m_cnt == DF) begin
            m_cnt = 0;
            m_groups_fed++;
            m_phase = M_WAIT;
            m_wait = 0;
            cd = (k_delay < 0) ? int'($urandom_range(1, TO + 2)) : k_delay;
          end
        end
      end
      M_WAIT: begin
        if (bus.fir_done) begin
          m_result = bus.fir_dotprod;
          exp_q.push_back(m_result);
          m_phase = M_WRITE;
        end else begin
          m_wait++;
          if (m_wait == TO) begin
            m_err = 1'b1;
            m_phase = M_IDLE;
          end
        end
      end
      M_WRITE: begin
        if (!bus.out_full) begin
          if (m_samples < 65535) m_samples++;
          m_phase = bus.enable ? M_FEED : M_IDLE;
        end else if (m_stall < 65535) begin
          m_stall++;
        end
      end
      default: m_phase = M_IDLE;
    endcase
    #1;
  endtask

  // Push scoreboard: every output FIFO write must match the oldest captured result
  always @(negedge clock) begin
    if (bus.out_wr_en === 1'b1) begin
      push_log.push_back(bus.out_din);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_push: got 0x%0h with no result pending at %0t", bus.out_din, $time);
      end else begin
        check("push_data", bus.out_din, exp_q.pop_front());
      end
    end
  end

  task automatic load(input int n);
    in_q.delete();
    for (int i = 0; i < n; i++) in_q.push_back($urandom);
  endtask

  task automatic clear_logs();
    push_log.delete();
    dut_pops = 0;
  endtask

  task automatic run_groups(input int n, input string name);
    bit ok;
    target = m_groups_fed + n;
    run_en = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (m_groups_fed >= target && m_phase == M_IDLE) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    step();
    run_en = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_budget: got no completion expected idle within 600 cycles", name);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_rd_en"}, 32'(bus.in_rd_en), 0);
    check({name, "_fir_valid"}, 32'(bus.fir_valid), 0);
    check({name, "_out_wr_en"}, 32'(bus.out_wr_en), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_out_din"}, bus.out_din, 0);
    check({name, "_error"}, 32'(error), 0);
    check({name, "_samples"}, 32'(samples_out), 0);
    check({name, "_stall"}, 32'(stall_cycles), 0);
  endtask

  // Asynchronous reset asserted between edges, released between edges
  task automatic do_reset(input string name);
    reset = 1'b0;
    #1;
    check_reset_outputs(name);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.enable = 1'b0;
    bus.in_empty = 1'b1;
    bus.in_dout = '0;
    bus.fir_rd_en = 1'b1;
    bus.fir_dotprod = '0;
    bus.fir_done = 1'b0;
    bus.out_full = 1'b0;
    #1;
    check_reset_outputs("por");
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Basic: two groups, fixed results
    clear_logs();
    load(8);
    dot_q = '{32'h0000_0123, 32'h0000_0456};
    k_delay = 3;
    run_groups(2, "basic");
    check("basic_pops", dut_pops, 8);
    check("basic_push_cnt", push_log.size(), 2);
    if (push_log.size() == 2) begin
      check("basic_push0", push_log[0], 32'h0000_0123);
      check("basic_push1", push_log[1], 32'h0000_0456);
    end
    check("basic_samples", 32'(samples_out), 2);

    // Starvation: FIFO empty every other cycle
    clear_logs();
    load(4);
    k_starve = 1'b1;
    run_groups(1, "starve");
    k_starve = 1'b0;
    check("starve_pops", dut_pops, 4);
    check("starve_push_cnt", push_log.size(), 1);

    // Backpressure: output FIFO full for 5 cycles
    clear_logs();
    load(4);
    dot_q = '{32'hBEEF_0001};
    bp_left = 5;
    run_groups(1, "bp");
    check("bp_stall", 32'(stall_cycles), 5);
    check("bp_push_cnt", push_log.size(), 1);
    if (push_log.size() == 1) check("bp_push_val", push_log[0], 32'hBEEF_0001);

    // Timeout: FIR never answers, then a normal group
    clear_logs();
    load(4);
    k_delay = 0;
    run_groups(1, "timeout");
    check("to_error", 32'(error), 1);
    check("to_busy", 32'(busy), 0);
    check("to_push_cnt", push_log.size(), 0);
    load(4);
    dot_q = '{32'h0000_0777};
    k_delay = 3;
    run_groups(1, "to_rerun");
    check("to_rerun_push_cnt", push_log.size(), 1);
    if (push_log.size() == 1) check("to_rerun_val", push_log[0], 32'h0000_0777);
    check("to_rerun_error", 32'(error), 1);

    // Spurious done mid-group
    do_reset("rst_a");
    clear_logs();
    load(4);
    dot_q = '{32'h0000_0999};
    spur_after_pop = 2;
    run_groups(1, "spur");
    check("spur_error", 32'(error), 1);
    check("spur_pops", dut_pops, 4);
    check("spur_push_cnt", push_log.size(), 1);

    // Reset after two pops of a group
    clear_logs();
    load(8);
    target = m_groups_fed + 1;
    run_en = 1'b1;
    for (int c = 0; c < 50 && m_cnt < 2; c++) step();
    check("rst_mid_pops", dut_pops, 2);
    run_en = 1'b0;
    do_reset("rst_mid");
    clear_logs();
    run_groups(1, "rst_after");
    check("rst_after_pops", dut_pops, 4);
    check("rst_after_push_cnt", push_log.size(), 1);

    // Randomized traffic
    do_reset("rst_b");
    k_rdy_rand = 1'b1;
    k_full_rand = 1'b1;
    k_delay = -1;
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 3));
      k_starve = $urandom_range(0, 1) == 1;
      load(n * int'(DF));
      run_groups(n, "rand");
    end

    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
